// File: rtl/systolic_gemm_engine.sv
// Output-stationary N x N systolic GEMM engine (C = A*B) with internal operand skew,
// valid/ready operand and result streams, and saturating or wrapping accumulators.
module systolic_gemm_engine #(
    parameter int unsigned N        = 4,
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 40,
    parameter int unsigned KMAX     = 64,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(KMAX+1)-1:0]    k_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N*DW-1:0]              a_col,
    input  logic [N*DW-1:0]              b_row,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N*AW-1:0]              out_row,
    output logic [$clog2(N)-1:0]         out_idx,
    output logic                         done,
    output logic                         ovf
);
    localparam int unsigned KW = $clog2(KMAX + 1);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned FW = $clog2(2 * N);

    typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDrain} state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_len_q, k_len_d;
    logic [KW-1:0]   beat_q, beat_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            done_q, done_d;
    logic            ovf_q;
    logic            accept, advance;

    logic signed [DW-1:0]   a_lane [N];
    logic signed [DW-1:0]   b_lane [N];
    logic signed [DW-1:0]   a_edge [N];
    logic signed [DW-1:0]   b_edge [N];
    logic signed [DW-1:0]   a_in   [N][N];
    logic signed [DW-1:0]   b_in   [N][N];
    logic signed [DW-1:0]   a_reg  [N][N];
    logic signed [DW-1:0]   b_reg  [N][N];
    logic signed [2*DW-1:0] prod   [N][N];
    logic [AW:0]            sum    [N][N];
    logic signed [AW-1:0]   acc_q  [N][N];
    logic signed [AW-1:0]   acc_d  [N][N];
    logic [N-1:0][N-1:0]    pe_ovf;

    assign accept  = (state_q == StIdle) && start && (k_len != '0) && (32'(k_len) <= KMAX);
    // FLUSH lasts 2N cycles but only the first 2N-1 move the array; the last loads DRAIN.
    assign advance = ((state_q == StFeed) && in_valid) ||
                     ((state_q == StFlush) && (flush_q != FW'(2 * N - 1)));

    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StFeed;
                    k_len_d = k_len;
                    beat_d  = '0;
                    idx_d   = '0;
                end
            end
            StFeed: begin
                if (in_valid) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_d == k_len_q) begin
                        state_d = StFlush;
                        flush_d = '0;
                    end
                end
            end
            StFlush: begin
                flush_d = flush_q + FW'(1);
                if (flush_q == FW'(2 * N - 1)) state_d = StDrain;
            end
            StDrain: begin
                if (out_ready) begin
                    if (idx_q == IW'(N - 1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            k_len_q <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_lane[i] = (state_q == StFeed) ? a_col[i*DW +: DW] : '0;
            b_lane[i] = (state_q == StFeed) ? b_row[i*DW +: DW] : '0;
        end
    end

    // Lane i of each operand is delayed by i advances so the array sees skewed wavefronts.
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_edge[i] = a_lane[i];
            assign b_edge[i] = b_lane[i];
        end else begin : g_delay
            logic signed [DW-1:0] a_dl [i];
            logic signed [DW-1:0] b_dl [i];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int d = 0; d < i; d++) begin
                        a_dl[d] <= '0;
                        b_dl[d] <= '0;
                    end
                end else if (advance) begin
                    a_dl[0] <= a_lane[i];
                    b_dl[0] <= b_lane[i];
                    for (int d = 1; d < i; d++) begin
                        a_dl[d] <= a_dl[d-1];
                        b_dl[d] <= b_dl[d-1];
                    end
                end
            end
            assign a_edge[i] = a_dl[i-1];
            assign b_edge[i] = b_dl[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = a_edge[i];
            b_in[0][i] = b_edge[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_reg[i][j-1];
                b_in[j][i] = b_reg[j-1][i];
            end
        end
    end

    always_comb begin
        pe_ovf = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j] = (2*DW)'(a_in[i][j]) * (2*DW)'(b_in[i][j]);
                sum[i][j]  = {acc_q[i][j][AW-1], acc_q[i][j]} +
                             {{(AW+1-2*DW){prod[i][j][2*DW-1]}}, prod[i][j]};
                pe_ovf[i][j] = sum[i][j][AW] ^ sum[i][j][AW-1];
                if (pe_ovf[i][j] && SATURATE) begin
                    acc_d[i][j] = sum[i][j][AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
                end else begin
                    acc_d[i][j] = sum[i][j][AW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j] <= '0;
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                end
            end
            ovf_q <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j] <= acc_d[i][j];
                    a_reg[i][j] <= a_in[i][j];
                    b_reg[i][j] <= b_in[i][j];
                end
            end
            if (|pe_ovf) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        out_row = '0;
        if (state_q == StDrain) begin
            for (int j = 0; j < N; j++) out_row[j*AW +: AW] = acc_q[idx_q][j];
        end
    end

    assign in_ready  = (state_q == StFeed);
    assign out_valid = (state_q == StDrain);
    assign busy      = (state_q != StIdle);
    assign out_idx   = idx_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Directed bench for systolic_gemm_engine: scoreboard of expected C rows from a
// behavioural accumulate model, plus two 32-bit-accumulator instances for overflow modes.
module tb_systolic_gemm_engine;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int AW   = 40;
    localparam int AWS  = 32;
    localparam int KMAX = 64;

    logic            clk = 1'b0;
    logic            reset, start, in_valid, out_ready;
    logic [6:0]      k_len;
    logic [N*DW-1:0] a_col, b_row;

    logic             in_ready, busy, out_valid, done, ovf;
    logic [N*AW-1:0]  out_row;
    logic [1:0]       out_idx;
    logic             s_in_ready, s_busy, s_out_valid, s_done, s_ovf;
    logic [N*AWS-1:0] s_out_row;
    logic [1:0]       s_out_idx;
    logic             w_in_ready, w_busy, w_out_valid, w_done, w_ovf;
    logic [N*AWS-1:0] w_out_row;
    logic [1:0]       w_out_idx;

    systolic_gemm_engine #(.N(N), .DW(DW), .AW(AW), .KMAX(KMAX), .SATURATE(1'b1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(in_ready), .a_col(a_col), .b_row(b_row), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_idx(out_idx), .done(done), .ovf(ovf)
    );
    systolic_gemm_engine #(.N(N), .DW(DW), .AW(AWS), .KMAX(KMAX), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(s_in_ready), .a_col(a_col), .b_row(b_row), .busy(s_busy),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_row(s_out_row),
        .out_idx(s_out_idx), .done(s_done), .ovf(s_ovf)
    );
    systolic_gemm_engine #(.N(N), .DW(DW), .AW(AWS), .KMAX(KMAX), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid),
        .in_ready(w_in_ready), .a_col(a_col), .b_row(b_row), .busy(w_busy),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_row(w_out_row),
        .out_idx(w_out_idx), .done(w_done), .ovf(w_ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int a_m [N][KMAX];
    int b_m [KMAX][N];

    logic [N*AW-1:0]  q_main [$];
    logic [N*AWS-1:0] q_sat  [$];
    logic [N*AWS-1:0] q_wrap [$];
    bit e_ovf, e_ovf_s, e_ovf_w;

    task automatic chk(input string tag, input logic [N*AW-1:0] obs, input logic [N*AW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sequential accumulate with per-step clamp or wrap at an aw-bit signed range.
    function automatic longint model_c(input int i, input int j, input int k, input int aw,
                                       input bit sat, output bit ov);
        longint acc, s, mx, mn;
        acc = 0;
        ov  = 1'b0;
        mx  = (longint'(1) <<< (aw - 1)) - 1;
        mn  = -(longint'(1) <<< (aw - 1));
        for (int kk = 0; kk < k; kk++) begin
            s = acc + longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
            if (s > mx || s < mn) begin
                ov = 1'b1;
                if (sat) s = (s > mx) ? mx : mn;
                else     s = (s <<< (64 - aw)) >>> (64 - aw);
            end
            acc = s;
        end
        return acc;
    endfunction

    task automatic push_expect(input int k, input bit aux);
        logic [N*AW-1:0]  row;
        logic [N*AWS-1:0] rs, rw;
        longint c;
        bit ov;
        e_ovf = 1'b0; e_ovf_s = 1'b0; e_ovf_w = 1'b0;
        for (int i = 0; i < N; i++) begin
            row = '0; rs = '0; rw = '0;
            for (int j = 0; j < N; j++) begin
                c = model_c(i, j, k, AW, 1'b1, ov);
                row[j*AW +: AW] = c[AW-1:0];
                e_ovf |= ov;
                c = model_c(i, j, k, AWS, 1'b1, ov);
                rs[j*AWS +: AWS] = c[AWS-1:0];
                e_ovf_s |= ov;
                c = model_c(i, j, k, AWS, 1'b0, ov);
                rw[j*AWS +: AWS] = c[AWS-1:0];
                e_ovf_w |= ov;
            end
            q_main.push_back(row);
            if (aux) begin
                q_sat.push_back(rs);
                q_wrap.push_back(rw);
            end
        end
    endtask

    task automatic drive_beat(input int kk);
        for (int i = 0; i < N; i++) begin
            a_col[i*DW +: DW] = a_m[i][kk][DW-1:0];
            b_row[i*DW +: DW] = b_m[kk][i][DW-1:0];
        end
        in_valid = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_row"},   out_row,   0);
        chk({tag, "_out_idx"},   out_idx,   0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_ovf"},       ovf,       0);
    endtask

    task automatic run_job(input int k, input bit stall_in, input bit stall_out,
                           input bit pokes, input bit aux);
        int st, f, beat, waited;
        logic [N*AW-1:0]  exp_row;
        logic [N*AWS-1:0] exp_s, exp_w;
        push_expect(k, aux);
        start = 1'b1;
        k_len = 7'(k);
        @(posedge clk); #1;
        start = 1'b0;
        st = cyc;
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        chk("done_one_cycle", done, 0);
        beat = 0;
        while (beat < k) begin
            drive_beat(beat);
            if (pokes && beat == 1) begin
                start = 1'b1;
                k_len = 7'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            beat++;
            if (stall_in && (beat == 1 || beat == 3)) begin
                in_valid = 1'b0;
                a_col = {$urandom, $urandom};
                b_row = {$urandom, $urandom};
                repeat (2) @(posedge clk);
                #1;
            end
        end
        f = cyc;
        // Junk beats outside FEED must not reach the array.
        in_valid = 1'b1;
        a_col = {$urandom, $urandom};
        b_row = {$urandom, $urandom};
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("out_valid_latency", cyc - f, 2 * N);
        for (int r = 0; r < N; r++) begin
            exp_row = q_main.pop_front();
            if (aux) begin
                exp_s = q_sat.pop_front();
                exp_w = q_wrap.pop_front();
            end
            if (stall_out && r == 2) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_idx", out_idx, 2);
                    chk("stall_row", out_row, exp_row);
                end
                out_ready = 1'b1;
            end
            chk("row_valid", out_valid, 1);
            chk("row_idx", out_idx, r);
            chk("row_data", out_row, exp_row);
            if (aux) begin
                chk("sat_row", s_out_row, exp_s);
                chk("wrap_row", w_out_row, exp_w);
            end
            if (pokes && r == 1) begin
                start = 1'b1;
                k_len = 7'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("busy_drop", busy, 0);
        chk("ovf", ovf, e_ovf);
        if (aux) begin
            chk("sat_ovf", s_ovf, e_ovf_s);
            chk("wrap_ovf", w_ovf, e_ovf_w);
        end
        if (!stall_in && !stall_out) chk("job_cycles", cyc - st, k + 3 * N);
        in_valid = 1'b0;
    endtask

    task automatic set_job1();
        for (int i = 0; i < N; i++) begin
            for (int kk = 0; kk < 4; kk++) begin
                a_m[i][kk] = (i == kk) ? 1 : 0;
                b_m[kk][i] = 4 * kk + i + 1;
            end
        end
    endtask

    task automatic fill_all(input int k, input int v);
        for (int i = 0; i < N; i++) begin
            for (int kk = 0; kk < k; kk++) begin
                a_m[i][kk] = v;
                b_m[kk][i] = v;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_col = '0; b_row = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        reset = 1'b1;
        @(posedge clk); #1;

        set_job1();
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(4, 1'b1, 1'b1, 1'b1, 1'b0);

        fill_all(4, -32768);
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b1);

        fill_all(KMAX, -32768);
        run_job(KMAX, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) begin
            a_m[i][0] = i + 1;
            b_m[0][i] = -(i + 1);
        end
        run_job(1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) begin
            for (int kk = 0; kk < 7; kk++) begin
                a_m[i][kk] = int'($urandom_range(65535)) - 32768;
                b_m[kk][i] = int'($urandom_range(65535)) - 32768;
            end
        end
        run_job(7, 1'b0, 1'b0, 1'b0, 1'b0);

        start = 1'b1; k_len = 7'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("klen0_busy", busy, 0);
        chk("klen0_in_ready", in_ready, 0);
        start = 1'b1; k_len = 7'd65;
        @(posedge clk); #1;
        start = 1'b0;
        chk("klen65_busy", busy, 0);

        set_job1();
        start = 1'b1; k_len = 7'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int kk = 0; kk < 2; kk++) begin
            drive_beat(kk);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        chk_reset("mid");
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/systolic_gemm_engine.md
# systolic_gemm_engine

Parametrised N×N output-stationary systolic matrix-multiply engine computing C = A·B for signed integer operands with runtime reduction depth. Successor to the fixed 4×4 `systolic_array`: operand skewing is internal (host streams unskewed columns of A and rows of B), input and output use valid/ready handshakes, and accumulators are wide with optional saturation. It sits between the operand buffers and the result writeback path of the TPU datapath.

## Interface
- `N`, 4: array dimension (PE grid N×N, C is N×N), 2..16
- `DW`, 16: signed operand width
- `AW`, 40: signed accumulator / result width, ≥ 2·DW
- `KMAX`, 64: maximum reduction depth
- `SATURATE`, 1: 1 = accumulators clamp at AW bounds; 0 = two's-complement wrap
- `clk` in 1: clock; all state on rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: job start pulse, sampled in IDLE only
- `k_len` in $clog2(KMAX+1): reduction depth for the job, latched on start
- `in_valid` in 1: operand beat valid
- `in_ready` out 1: engine accepts operand beat
- `a_col` in N·DW: column k of A; lane i = A[i][k]
- `b_row` in N·DW: row k of B; lane j = B[k][j]
- `busy` out 1: job in progress (FEED, FLUSH, DRAIN)
- `out_valid` out 1: result row valid
- `out_ready` in 1: sink accepts result row
- `out_row` out N·AW: row out_idx of C; lane j = C[out_idx][j]
- `out_idx` out $clog2(N): current result row index
- `done` out 1: one-cycle pulse, job complete
- `ovf` out 1: sticky overflow flag for current job

## Operation
- FSM: IDLE → FEED → FLUSH → DRAIN → IDLE.
- IDLE: in_ready=0. `start`=1 with 1 ≤ k_len ≤ KMAX: clear all accumulators, clear ovf, latch k_len, → FEED. start with k_len=0 or >KMAX: ignored, stay IDLE.
- FEED: in_ready=1. Each handshake (in_valid && in_ready) is one array advance: lane i of A delayed i advances, lane j of B delayed j advances, zeros injected into unused skew slots. No handshake → whole array frozen (no advance, no accumulate). After k_len-th beat → FLUSH.
- FLUSH: in_ready=0; array advances every cycle with zero operands for exactly 2N-1 cycles, then → DRAIN.
- PE(i,j): on each advance acc += a_reg·b_reg (full 2·DW product sign-extended to AW); a_reg forwards right, b_reg forwards down.
- Overflow: if true sum leaves AW signed range, SATURATE=1 clamps to ±bound, SATURATE=0 wraps; either way ovf set, held until next accepted start.
- DRAIN: out_valid=1, out_row = accumulator row out_idx, out_idx starts 0; advances on out_valid && out_ready. out_row/out_idx stable while out_ready=0. After row N-1 accepted: done=1 for one cycle, busy=0, → IDLE.
- start while busy: ignored. in_valid outside FEED: ignored.
- `reset` low at any time: immediate return to IDLE, all state cleared, partial job discarded.

## Timing
- Reset values: in_ready=0, busy=0, out_valid=0, out_row=0, out_idx=0, done=0, ovf=0.
- start accepted at edge e: busy=1 and in_ready=1 after e.
- Last beat accepted at edge f: out_valid=1 after edge f+2N (2N-1 FLUSH cycles + 1 register stage).
- Full-throughput job (no stalls, out_ready=1): start edge to done pulse = k_len + 2N + N cycles; done asserted in cycle after final row handshake, same cycle busy drops.
- Back-to-back: start accepted in cycle after done.
- in_ready/out_valid are registered outputs; no combinational path from in_valid or out_ready to them.

## Test plan
- N=4, k_len=4, A=I, B[k][j]=4k+j+1, no stalls → out rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, ovf=0, out_valid 8 cycles after last beat.
- Same job, in_valid low 2 cycles after beats 1 and 3, out_ready low 3 cycles on row 2 → identical results, row 2 data and out_idx=2 held stable during stall.
- AW=32, SATURATE=1, k_len=4, all operands -32768 → every C entry 2147483647, ovf=1; SATURATE=0 → every entry 0 (wrap of 2^32), ovf=1.
- k_len=KMAX=64, all operands -32768, AW=40 → every entry 2^36, ovf=0; k_len=1, A[i][0]=i+1, B[0][j]=-(j+1) → C[i][j]=-(i+1)(j+1).
- Reset low after 2 beats of FEED → all outputs at reset values immediately; next job (first test) yields correct results.
- start with k_len=0 → busy stays 0; start pulsed during FEED and DRAIN → no effect on running job or results.
